exec_pipe_stage: RTL and testbench



---
 rtl/exec_pkg.sv | 43 ++++
 rtl/exec_mul_seq.sv | 63 ++++++
 rtl/exec_pipe_stage.sv | 207 ++++++++++++++++++++
 tb/tb_exec_pipe_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared decode constants, control-bit positions and FSM states for the
// LEGv8 execute stage.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_ORR   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_MUL   = 4'b1000,
        ALU_NOR   = 4'b1100
    } alu_t;

    localparam logic [10:0] OP_R_ADD = 11'b10001011000;
    localparam logic [10:0] OP_R_SUB = 11'b11001011000;
    localparam logic [10:0] OP_R_AND = 11'b10001010000;
    localparam logic [10:0] OP_R_ORR = 11'b10101010000;
    localparam logic [10:0] OP_R_MUL = 11'b10011011000;

    localparam logic [9:0] OP_I_ADD = 10'b1001000100;
    localparam logic [9:0] OP_I_SUB = 10'b1101000100;
    localparam logic [9:0] OP_I_AND = 10'b1001001000;
    localparam logic [9:0] OP_I_ORR = 10'b1011001000;

    localparam int unsigned CTRL_B          = 6;
    localparam int unsigned CTRL_BZ         = 5;
    localparam int unsigned CTRL_BNZ        = 4;
    localparam int unsigned CTRL_MEM_WRITE  = 3;
    localparam int unsigned CTRL_MEM_READ   = 2;
    localparam int unsigned CTRL_MEM_TO_REG = 1;
    localparam int unsigned CTRL_REG_WRITE  = 0;

    typedef enum logic {
        ST_IDLE,
        ST_MUL_BUSY
    } state_t;

    function automatic logic branch_taken(input logic [6:0] ctrl, input logic z);
        return ctrl[CTRL_B] | (ctrl[CTRL_BZ] & z) | (ctrl[CTRL_BNZ] & ~z);
    endfunction

endpackage

// File: rtl/exec_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low XLEN bits
// of the product, abortable by flush.
module exec_mul_seq
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int unsigned CW = $clog2(XLEN);

    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_next;
    logic [CW-1:0]   cnt;
    logic            busy;
    logic            last;

    assign last     = (cnt == CW'(XLEN - 1));
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    // The final partial sum is forwarded so the caller loads it on the last edge.
    assign done     = busy & last;
    assign product  = acc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (flush) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (last) begin
                cnt  <= '0;
                busy <= 1'b0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/exec_pipe_stage.sv
// LEGv8 execute stage: ALU decode, operand select, flags, branch resolution
// and a handshaked EX/MEM output register, with an iterative MUL path.
module exec_pipe_stage
    import exec_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [1:0]      alu_src,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      ctrl_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_branch_target,
    output logic [4:0]      out_rd,
    output logic [6:0]      out_ctrl,
    output logic [3:0]      out_flags,
    output logic            out_pc_src,
    output logic            out_illegal
);

    state_t          state;
    alu_t            alu_sel;
    logic            illegal;
    logic            is_mul;
    logic            accept;
    logic [XLEN-1:0] opb;
    logic [XLEN:0]   add_w;
    logic [XLEN:0]   sub_w;
    logic [XLEN-1:0] res;
    logic            c_flag;
    logic            v_flag;
    logic            z_flag;
    logic [6:0]      ctrl_eff;
    logic [XLEN-1:0] target;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;
    logic            mul_z;
    logic [XLEN-1:0] h_target;
    logic [XLEN-1:0] h_store;
    logic [4:0]      h_rd;
    logic [6:0]      h_ctrl;
    logic            unused_bits;

    assign unused_bits = ^instr[9:5];

    always_comb begin
        alu_sel = ALU_ADD;
        illegal = 1'b0;
        case (alu_op)
            2'b00: alu_sel = ALU_ADD;
            2'b01: alu_sel = ALU_PASSB;
            2'b10: begin
                case (instr[31:21])
                    OP_R_ADD: alu_sel = ALU_ADD;
                    OP_R_SUB: alu_sel = ALU_SUB;
                    OP_R_AND: alu_sel = ALU_AND;
                    OP_R_ORR: alu_sel = ALU_ORR;
                    OP_R_MUL: begin
                        alu_sel = ALU_MUL;
                        illegal = ~MUL_EN;
                    end
                    default:  illegal = 1'b1;
                endcase
            end
            default: begin
                case (instr[31:22])
                    OP_I_ADD: alu_sel = ALU_ADD;
                    OP_I_SUB: alu_sel = ALU_SUB;
                    OP_I_AND: alu_sel = ALU_AND;
                    OP_I_ORR: alu_sel = ALU_ORR;
                    default:  illegal = 1'b1;
                endcase
            end
        endcase
        if (alu_src == 2'b11) illegal = 1'b1;
    end

    always_comb begin
        case (alu_src)
            2'b00:   opb = rs2_data;
            2'b01:   opb = imm;
            default: opb = {{(XLEN-12){1'b0}}, instr[21:10]};
        endcase
    end

    // SUB is a + ~b + 1 so the carry-out directly gives the no-borrow flag.
    assign add_w = {1'b0, rs1_data} + {1'b0, opb};
    assign sub_w = {1'b0, rs1_data} + {1'b0, ~opb} + (XLEN+1)'(1);

    always_comb begin
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (alu_sel)
            ALU_ADD: begin
                res    = add_w[XLEN-1:0];
                c_flag = add_w[XLEN];
                v_flag = (rs1_data[XLEN-1] == opb[XLEN-1]) & (add_w[XLEN-1] != rs1_data[XLEN-1]);
            end
            ALU_SUB: begin
                res    = sub_w[XLEN-1:0];
                c_flag = sub_w[XLEN];
                v_flag = (rs1_data[XLEN-1] != opb[XLEN-1]) & (sub_w[XLEN-1] != rs1_data[XLEN-1]);
            end
            ALU_AND:   res = rs1_data & opb;
            ALU_ORR:   res = rs1_data | opb;
            ALU_NOR:   res = ~(rs1_data | opb);
            ALU_PASSB: res = opb;
            default:   res = '0;
        endcase
        if (illegal) begin
            res    = '0;
            c_flag = 1'b0;
            v_flag = 1'b0;
        end
    end

    assign z_flag   = ~|res;
    assign ctrl_eff = illegal ? '0 : ctrl_in;
    assign target   = pc + (imm << 2);
    assign is_mul   = (alu_sel == ALU_MUL) & ~illegal;
    assign in_ready = (state == ST_IDLE) & (~out_valid | out_ready) & ~flush & ~reset;
    assign accept   = in_valid & in_ready;
    assign mul_z    = ~|mul_product;

    exec_mul_seq #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept & is_mul),
        .flush   (flush),
        .a       (rs1_data),
        .b       (opb),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            out_valid         <= 1'b0;
            out_result        <= '0;
            out_store_data    <= '0;
            out_branch_target <= '0;
            out_rd            <= '0;
            out_ctrl          <= '0;
            out_flags         <= '0;
            out_pc_src        <= 1'b0;
            out_illegal       <= 1'b0;
            h_target          <= '0;
            h_store           <= '0;
            h_rd              <= '0;
            h_ctrl            <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else if (state == ST_MUL_BUSY) begin
            if (mul_done) begin
                state             <= ST_IDLE;
                out_valid         <= 1'b1;
                out_result        <= mul_product;
                out_store_data    <= h_store;
                out_branch_target <= h_target;
                out_rd            <= h_rd;
                out_ctrl          <= h_ctrl;
                out_flags         <= {mul_product[XLEN-1], mul_z, 2'b00};
                out_pc_src        <= branch_taken(h_ctrl, mul_z);
                out_illegal       <= 1'b0;
            end
        end else if (accept) begin
            if (is_mul) begin
                // Output register is free (consumed or empty) on MUL accept.
                state     <= ST_MUL_BUSY;
                out_valid <= 1'b0;
                h_target  <= target;
                h_store   <= rs2_data;
                h_rd      <= instr[4:0];
                h_ctrl    <= ctrl_in;
            end else begin
                out_valid         <= 1'b1;
                out_result        <= res;
                out_store_data    <= rs2_data;
                out_branch_target <= target;
                out_rd            <= instr[4:0];
                out_ctrl          <= ctrl_eff;
                out_flags         <= {res[XLEN-1], z_flag, c_flag, v_flag};
                out_pc_src        <= branch_taken(ctrl_eff, z_flag);
                out_illegal       <= illegal;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exec_pipe_stage.sv
// Table-driven scoreboard bench for exec_pipe_stage plus hand sequences for
// backpressure, MUL overlap, flush and mid-operation reset.
module tb_exec_pipe_stage;

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [1:0]  src;
        logic [1:0]  op;
        logic [6:0]  ctrl;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] res;
        logic [3:0]  flags;
        logic        pc_src;
        logic        ill;
        logic [6:0]  ectrl;
        logic [63:0] tgt;
        int          lat;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] imm;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [1:0]  alu_src;
    logic [1:0]  alu_op;
    logic [6:0]  ctrl_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [63:0] out_store_data;
    logic [63:0] out_branch_target;
    logic [4:0]  out_rd;
    logic [6:0]  out_ctrl;
    logic [3:0]  out_flags;
    logic        out_pc_src;
    logic        out_illegal;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[19];
    vec_t sb[$];
    vec_t tmp;
    bit   held;
    bit   seen;

    exec_pipe_stage #(.XLEN(64), .MUL_EN(1'b1)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .pc                (pc),
        .instr             (instr),
        .imm               (imm),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .alu_src           (alu_src),
        .alu_op            (alu_op),
        .ctrl_in           (ctrl_in),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_result        (out_result),
        .out_store_data    (out_store_data),
        .out_branch_target (out_branch_target),
        .out_rd            (out_rd),
        .out_ctrl          (out_ctrl),
        .out_flags         (out_flags),
        .out_pc_src        (out_pc_src),
        .out_illegal       (out_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] r_ins(input logic [10:0] opc, input logic [4:0] rd);
        return {opc, 16'h0000, rd};
    endfunction

    function automatic logic [31:0] i_ins(input logic [9:0] opc, input logic [11:0] im, input logic [4:0] rd);
        return {opc, im, 5'd0, rd};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_ctl"}, 64'({out_valid, in_ready, out_pc_src, out_illegal, out_ctrl, out_flags, out_rd}), 64'd0);
        check({nm, "_data"}, out_result | out_store_data | out_branch_target, 64'd0);
    endtask

    // Caller must be at a negedge; returns 1 time unit after the accepting edge.
    task automatic send(input vec_t v);
        int n = 0;
        pc       = v.pc;
        instr    = v.instr;
        imm      = v.imm;
        rs1_data = v.rs1;
        rs2_data = v.rs2;
        alu_src  = v.src;
        alu_op   = v.op;
        ctrl_in  = v.ctrl;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check({v.name, "_accept"}, 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            sb.push_back(v);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic expect_out();
        vec_t e;
        int   k = 0;
        bit   low_ok = 1'b1;
        @(negedge clk);
        while (!out_valid && k < 200) begin
            if (in_ready) low_ok = 1'b0;
            k++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got output with no expected entry, result %h", out_result);
            return;
        end
        e = sb.pop_front();
        check({e.name, "_latency"}, 64'(k), 64'(e.lat));
        if (e.lat > 0) check({e.name, "_inready_low"}, 64'(low_ok), 64'd1);
        check({e.name, "_result"}, out_result, e.res);
        check({e.name, "_flags"}, 64'(out_flags), 64'(e.flags));
        check({e.name, "_ctl"}, 64'({out_pc_src, out_illegal, out_ctrl}), 64'({e.pc_src, e.ill, e.ectrl}));
        check({e.name, "_target"}, out_branch_target, e.tgt);
        check({e.name, "_store"}, out_store_data, e.rs2);
        check({e.name, "_rd"}, 64'(out_rd), 64'(e.instr[4:0]));
    endtask

    initial begin
        vecs[0]  = '{"add_r",        r_ins(11'h458, 5'd1),          2'b00, 2'b10, 7'h01, 64'h0,    64'h0,  64'd5,   64'd7,   64'd12,                4'b0000, 1'b0, 1'b0, 7'h01, 64'h0,    0};
        vecs[1]  = '{"cbz",          32'hB400_0000,                 2'b00, 2'b01, 7'h20, 64'h100,  64'h4,  64'h55,  64'h0,   64'h0,                 4'b0100, 1'b1, 1'b0, 7'h20, 64'h110,  0};
        vecs[2]  = '{"add_ovf",      r_ins(11'h458, 5'd2),          2'b00, 2'b10, 7'h01, 64'h0,    64'h0,  MAXP,    64'd1,   MINN,                  4'b1001, 1'b0, 1'b0, 7'h01, 64'h0,    0};
        vecs[3]  = '{"sub_neg",      r_ins(11'h658, 5'd3),          2'b00, 2'b10, 7'h01, 64'h0,    64'h0,  64'd5,   64'd7,   64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0, 1'b0, 7'h01, 64'h0,    0};
        vecs[4]  = '{"sub_zero_bnz", r_ins(11'h658, 5'd4),          2'b00, 2'b10, 7'h10, 64'h200,  64'hFFFF_FFFF_FFFF_FFFE, 64'd9, 64'd9, 64'h0, 4'b0110, 1'b0, 1'b0, 7'h10, 64'h1F8, 0};
        vecs[5]  = '{"add_carry_b",  r_ins(11'h458, 5'd5),          2'b00, 2'b10, 7'h40, 64'h1000, 64'h10, ONES,    64'd1,   64'h0,                 4'b0110, 1'b1, 1'b0, 7'h40, 64'h1040, 0};
        vecs[6]  = '{"and_r",        r_ins(11'h450, 5'd6),          2'b00, 2'b10, 7'h01, 64'h0,    64'h0,  64'hF0F0, 64'hFF00, 64'hF000,            4'b0000, 1'b0, 1'b0, 7'h01, 64'h0,    0};
        vecs[7]  = '{"orr_r",        r_ins(11'h550, 5'd7),          2'b00, 2'b10, 7'h01, 64'h0,    64'h0,  MINN,    64'd1,   64'h8000_0000_0000_0001, 4'b1000, 1'b0, 1'b0, 7'h01, 64'h0,    0};
        vecs[8]  = '{"addi_zx",      i_ins(10'h244, 12'hFFF, 5'd8), 2'b10, 2'b11, 7'h01, 64'h40,   64'h0,  64'd1,   64'hAB,  64'h1000,              4'b0000, 1'b0, 1'b0, 7'h01, 64'h40,   0};
        vecs[9]  = '{"subi_zx",      i_ins(10'h344, 12'h001, 5'd9), 2'b10, 2'b11, 7'h01, 64'h0,    64'h0,  64'd0,   64'h0,   ONES,                  4'b1000, 1'b0, 1'b0, 7'h01, 64'h0,    0};
        vecs[10] = '{"andi_imm",     i_ins(10'h248, 12'h0, 5'd10),  2'b01, 2'b11, 7'h01, 64'h0,    64'hFF, 64'h1234, 64'h0,  64'h34,                4'b0000, 1'b0, 1'b0, 7'h01, 64'h3FC,  0};
        vecs[11] = '{"orri_imm",     i_ins(10'h2C8, 12'h0, 5'd11),  2'b01, 2'b11, 7'h01, 64'h0,    64'h100, 64'h0F, 64'h0,   64'h10F,               4'b0000, 1'b0, 1'b0, 7'h01, 64'h400,  0};
        vecs[12] = '{"passb",        32'h0000_000C,                 2'b01, 2'b01, 7'h01, 64'h10,   ONES,   64'h99,  64'h0,   ONES,                  4'b1000, 1'b0, 1'b0, 7'h01, 64'hC,    0};
        vecs[13] = '{"ill_src",      r_ins(11'h458, 5'd13),         2'b11, 2'b00, 7'h7F, 64'h0,    64'h0,  64'd5,   64'd7,   64'h0,                 4'b0100, 1'b0, 1'b1, 7'h00, 64'h0,    0};
        vecs[14] = '{"ill_rop",      r_ins(11'h7FF, 5'd14),         2'b00, 2'b10, 7'h41, 64'h0,    64'h0,  64'd5,   64'd7,   64'h0,                 4'b0100, 1'b0, 1'b1, 7'h00, 64'h0,    0};
        vecs[15] = '{"ill_iop",      i_ins(10'h3FF, 12'h0, 5'd15),  2'b01, 2'b11, 7'h01, 64'h0,    64'h0,  64'd5,   64'd7,   64'h0,                 4'b0100, 1'b0, 1'b1, 7'h00, 64'h0,    0};
        vecs[16] = '{"sub_vovf",     r_ins(11'h658, 5'd16),         2'b00, 2'b10, 7'h01, 64'h0,    64'h0,  MINN,    64'd1,   MAXP,                  4'b0011, 1'b0, 1'b0, 7'h01, 64'h0,    0};
        vecs[17] = '{"mul_neg",      r_ins(11'h4D8, 5'd9),          2'b00, 2'b10, 7'h01, 64'h0,    64'h0,  64'd3,   ONES,    64'hFFFF_FFFF_FFFF_FFFD, 4'b1000, 1'b0, 1'b0, 7'h01, 64'h0,    64};
        vecs[18] = '{"mul_drop",     r_ins(11'h4D8, 5'd10),         2'b00, 2'b10, 7'h01, 64'h20,   64'h2,  64'h1234_5678, 64'h10, 64'h1_2345_6780, 4'b0000, 1'b0, 1'b0, 7'h01, 64'h28,   64};

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pc        = '0;
        instr     = '0;
        imm       = '0;
        rs1_data  = '0;
        rs2_data  = '0;
        alu_src   = '0;
        alu_op    = '0;
        ctrl_in   = '0;

        repeat (2) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        for (int i = 0; i < 18; i++) begin
            send(vecs[i]);
            expect_out();
        end

        // Drain, then hold the first result while a second op waits.
        @(negedge clk);
        out_ready = 1'b0;
        send(vecs[6]);
        expect_out();
        fork
            send(vecs[7]);
            begin
                held = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    #1;
                    if (in_ready || !out_valid || out_result !== vecs[6].res) held = 1'b0;
                end
                check("bp_hold", 64'(held), 64'd1);
                out_ready = 1'b1;
            end
        join
        expect_out();

        // Output still valid with ready high: MUL accept consumes it and drops valid.
        send(vecs[18]);
        expect_out();

        send(vecs[17]);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_ready", 64'(in_ready), 64'd1);
        tmp  = sb.pop_back();
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_valid", 64'(seen), 64'd0);

        send(vecs[17]);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check_zero("reset_mid_mul");
        tmp = sb.pop_back();
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("reset_no_partial", 64'(seen), 64'd0);
        check("ready_after_mid_reset", 64'(in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
